spi_wave_loader: RTL and testbench

//  SPI slave front-end of the waveform generator. Receives 32-bit command frames from the MCU SPI master and decodes them.

---
 rtl/spi_wave_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_wave_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wave_loader.sv
// -----------------------------------------------------------------------------
// spi_wave_loader
//
// SPI slave front-end of the waveform generator. The MCU sends 32-bit command
// frames (mode 0, MSB first). Each frame is {cmd, index, value}:
//   cmd 0 : no operation
//   cmd 1 : write value to waveform RAM entry index (one-clk mem_we strobe)
//   cmd 2 : set the active waveform length to index (1..MEM_DEPTH)
// Anything else, or an out-of-range index/length, is rejected with frame_err.
// The previously received frame is shifted back out on MISO so the master can
// compare it with what it sent. SCK/SSEL/MOSI are oversampled in the clk
// domain, so SCK must be at most clk/4.
//
// Ports
//   clk        system clock
//   rst_n      synchronous reset, active low
//   SCK        SPI clock (idle low, data sampled on the rising edge)
//   MOSI       SPI data from the master, MSB first
//   SSEL       SPI slave select, active low
//   MISO       SPI data to the master, echo of the previous frame
//   mem_we     RAM write strobe, one clk wide
//   mem_addr   RAM write address, holds its last value between writes
//   mem_wdata  RAM write data, holds its last value between writes
//   wave_len   active waveform length in samples
//   rx_valid   one-clk pulse per accepted frame
//   frame_err  one-clk pulse per rejected frame
//
// Strobe latency, counted in clk edges starting with the edge that first
// samples the 32nd SCK rising edge high: sync stage 1, sync stage 2, edge
// register, entry into COMMIT, output register.
// -----------------------------------------------------------------------------
module spi_wave_loader #(
    parameter int CMD_W     = 4,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 14,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              SSEL,
    output logic              MISO,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] wave_len,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [CMD_W-1:0]  CMD_NOP   = CMD_W'(0);
    localparam logic [CMD_W-1:0]  CMD_WRITE = CMD_W'(1);
    localparam logic [CMD_W-1:0]  CMD_LEN   = CMD_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // Synchronisers and edge detection
    logic sck_s1, sck_s2, sck_d;
    logic ssel_s1, ssel_s2;
    logic mosi_s1, mosi_s2;
    logic sck_rise, sck_fall;
    logic mosi_bit;
    logic ssel_armed;

    // Frame engine
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] echo;

    // Decoded frame fields
    logic [CMD_W-1:0]  f_cmd;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_data;
    logic              addr_ok;
    logic              len_ok;

    // Next values of the registered outputs
    logic              we_nxt, rx_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_nxt, len_nxt;
    logic [DATA_W-1:0] wdata_nxt;

    // -------------------------------------------------------------------------
    // Input synchronisation. The edge pulses are registered together with the
    // MOSI sample that belongs to them so both line up in the same cycle.
    // ssel_armed stays low after reset until SSEL has been seen high, so a
    // reset in the middle of a frame cannot resume on the tail of that frame.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_s1     <= 1'b0;
            sck_s2     <= 1'b0;
            sck_d      <= 1'b0;
            ssel_s1    <= 1'b0;
            ssel_s2    <= 1'b0;
            mosi_s1    <= 1'b0;
            mosi_s2    <= 1'b0;
            sck_rise   <= 1'b0;
            sck_fall   <= 1'b0;
            mosi_bit   <= 1'b0;
            ssel_armed <= 1'b0;
        end else begin
            sck_s1     <= SCK;
            sck_s2     <= sck_s1;
            sck_d      <= sck_s2;
            ssel_s1    <= SSEL;
            ssel_s2    <= ssel_s1;
            mosi_s1    <= MOSI;
            mosi_s2    <= mosi_s1;
            sck_rise   <= sck_s2 & ~sck_d;
            sck_fall   <= ~sck_s2 & sck_d;
            mosi_bit   <= mosi_s2;
            ssel_armed <= ssel_armed | ssel_s2;
        end
    end

    assign f_cmd   = shreg[FRAME_W-1 -: CMD_W];
    assign f_addr  = shreg[DATA_W +: ADDR_W];
    assign f_data  = shreg[DATA_W-1:0];
    assign addr_ok = ({1'b0, f_addr} < DEPTH_V);
    assign len_ok  = (f_addr != '0) && ({1'b0, f_addr} <= DEPTH_V);

    // -------------------------------------------------------------------------
    // Next-state and decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        rx_nxt    = 1'b0;
        err_nxt   = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        len_nxt   = wave_len;

        case (state)
            IDLE: begin
                if (!ssel_s2 && ssel_armed) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (ssel_s2)                            state_nxt = IDLE;
                else if (sck_rise && bit_cnt == LAST_BIT) state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = ssel_s2 ? IDLE : SHIFT;
                case (f_cmd)
                    CMD_NOP: rx_nxt = 1'b1;
                    CMD_WRITE: begin
                        if (addr_ok) begin
                            we_nxt    = 1'b1;
                            addr_nxt  = f_addr;
                            wdata_nxt = f_data;
                            rx_nxt    = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                    CMD_LEN: begin
                        if (len_ok) begin
                            len_nxt = f_addr;
                            rx_nxt  = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                    default: err_nxt = 1'b1;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame engine and registered outputs. The shift path stays live in
    // COMMIT so an SCK edge landing there still counts toward the next frame.
    // The echo only shifts on falling edges that follow a rising edge of the
    // current frame; the trailing fall of the previous frame's last bit
    // arrives with bit_cnt back at 0 and must leave echo[MSB] in place.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            echo      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wave_len  <= DEPTH_V[ADDR_W-1:0];
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shreg   <= {shreg[FRAME_W-2:0], mosi_bit};
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end

            if (state == COMMIT) begin
                echo <= shreg;
            end else if (state == SHIFT && sck_fall && bit_cnt != '0) begin
                echo <= {echo[FRAME_W-2:0], 1'b0};
            end

            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            wave_len  <= len_nxt;
            rx_valid  <= rx_nxt;
            frame_err <= err_nxt;
        end
    end

    assign MISO = (state != IDLE) & echo[FRAME_W-1];

endmodule

// File: tb/tb_spi_wave_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_wave_loader
//
// Directed bench for spi_wave_loader. An SPI master model drives SCK at clk/6
// (4 clk low, 2 clk high), changes MOSI while SCK is low and captures MISO
// just before each rising edge. Monitors sampled on the falling clk edge count
// strobes and keep a RAM model written by mem_we.
// -----------------------------------------------------------------------------
module tb_spi_wave_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SCK;
    logic        MOSI;
    logic        SSEL;
    logic        MISO;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [13:0] mem_wdata;
    logic [13:0] wave_len;
    logic        rx_valid;
    logic        frame_err;

    always #5 clk = ~clk;

    spi_wave_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCK       (SCK),
        .MOSI      (MOSI),
        .SSEL      (SSEL),
        .MISO      (MISO),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .wave_len  (wave_len),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    int total = 0;
    int bad   = 0;

    // Strobe monitors and RAM model
    int          rx_cnt   = 0;
    int          we_cnt   = 0;
    int          err_cnt  = 0;
    int          both_cnt = 0;
    int          oob_cnt  = 0;
    logic [13:0] ram [0:255];

    always @(negedge clk) begin
        if (rx_valid === 1'b1)  rx_cnt++;
        if (frame_err === 1'b1) err_cnt++;
        if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (mem_we === 1'b1) begin
            we_cnt++;
            if (mem_addr < 14'd256) ram[mem_addr[7:0]] = mem_wdata;
            else                    oob_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [13:0] a, input logic [13:0] d);
        return {c, a, d};
    endfunction

    // Offset-binary 14-bit sine, 256 points per period
    function automatic logic [13:0] sine(input int i);
        real r;
        r = 8191.5 + 8191.0 * $sin(6.283185307179586 * real'(i) / 256.0);
        return 14'($rtoi(r));
    endfunction

    // Send frame bits hi..lo; cap returns what MISO showed before each rise.
    // Returns on the falling clk edge right after the second clk edge that
    // sees the last SCK rise.
    task automatic spi_bits(input logic [31:0] f, input int hi, input int lo, output logic [31:0] cap);
        cap = '0;
        for (int i = hi; i >= lo; i--) begin
            @(negedge clk);
            MOSI = f[i];
            repeat (3) @(negedge clk);
            cap[i] = MISO;
            SCK = 1'b1;
            repeat (2) @(negedge clk);
            SCK = 1'b0;
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        SSEL = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        SSEL = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Send one full frame and check how many of each strobe it produced
    task automatic send_checked(input string tag, input logic [31:0] f,
                                input int d_rx, input int d_we, input int d_err);
        int          rx0;
        int          we0;
        int          err0;
        logic [31:0] c;
        rx0  = rx_cnt;
        we0  = we_cnt;
        err0 = err_cnt;
        spi_bits(f, 31, 0, c);
        repeat (5) @(negedge clk);
        check({tag, ".rx_valid"},  32'(rx_cnt - rx0),   32'(d_rx));
        check({tag, ".mem_we"},    32'(we_cnt - we0),   32'(d_we));
        check({tag, ".frame_err"}, 32'(err_cnt - err0), 32'(d_err));
    endtask

    initial begin
        logic [31:0] cap;
        logic [31:0] prev;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [31:0] fc;
        int          rx0;
        int          we0;
        int          err0;
        int          echo_bad;
        int          ram_bad;

        rst_n = 1'b0;
        SCK   = 1'b0;
        MOSI  = 1'b0;
        SSEL  = 1'b1;

        // ---- 1: reset with SCK toggling -------------------------------------
        repeat (3) begin
            @(negedge clk);
            SCK = ~SCK;
        end
        @(negedge clk);
        check("rst.mem_we",    32'(mem_we),    32'd0);
        check("rst.rx_valid",  32'(rx_valid),  32'd0);
        check("rst.frame_err", 32'(frame_err), 32'd0);
        check("rst.wave_len",  32'(wave_len),  32'd256);
        check("rst.MISO",      32'(MISO),      32'd0);
        check("rst.mem_addr",  32'(mem_addr),  32'd0);
        check("rst.mem_wdata", 32'(mem_wdata), 32'd0);
        SCK   = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ---- 2: single write with latency check -----------------------------
        // Last rise sampled at edge E0; the strobe must appear at edge E0+4.
        frame_begin();
        fa = mk(4'h1, 14'd5, 14'h1FFF);
        spi_bits(fa, 31, 0, cap);            // now just after E1
        repeat (2) @(negedge clk);           // just after E3
        check("lat.early_we", 32'(mem_we),   32'd0);
        check("lat.early_rx", 32'(rx_valid), 32'd0);
        @(negedge clk);                      // just after E4
        check("lat.mem_we",    32'(mem_we),    32'd1);
        check("lat.rx_valid",  32'(rx_valid),  32'd1);
        check("lat.frame_err", 32'(frame_err), 32'd0);
        check("lat.mem_addr",  32'(mem_addr),  32'd5);
        check("lat.mem_wdata", 32'(mem_wdata), 32'h1FFF);
        @(negedge clk);                      // just after E5
        check("lat.we_width",  32'(mem_we),    32'd0);
        check("lat.addr_hold", 32'(mem_addr),  32'd5);
        check("lat.data_hold", 32'(mem_wdata), 32'h1FFF);
        frame_end();
        check("wr.rx_total", 32'(rx_cnt), 32'd1);
        check("wr.we_total", 32'(we_cnt), 32'd1);

        // ---- 3: 255-frame burst with SSEL held low ---------------------------
        rx0      = rx_cnt;
        we0      = we_cnt;
        err0     = err_cnt;
        echo_bad = 0;
        prev     = fa;
        frame_begin();
        for (int i = 0; i < 255; i++) begin
            fb = mk(4'h1, 14'(i), sine(i));
            spi_bits(fb, 31, 0, cap);
            if (cap !== prev) echo_bad++;
            prev = fb;
        end
        frame_end();
        ram_bad = 0;
        for (int i = 0; i < 255; i++) begin
            if (ram[i] !== sine(i)) ram_bad++;
        end
        check("burst.rx_valid",  32'(rx_cnt - rx0),   32'd255);
        check("burst.mem_we",    32'(we_cnt - we0),   32'd255);
        check("burst.frame_err", 32'(err_cnt - err0), 32'd0);
        check("burst.ram_bad",   32'(ram_bad),        32'd0);
        check("burst.echo_bad",  32'(echo_bad),       32'd0);
        check("burst.last_addr", 32'(mem_addr),       32'd254);

        // ---- 4: rejected frames and range boundaries ------------------------
        frame_begin();
        send_checked("err.cmd7",     mk(4'h7, 14'd3,   14'd9),     0, 0, 1);
        send_checked("err.addr300",  mk(4'h1, 14'd300, 14'h0123),  0, 0, 1);
        check("err.addr_hold", 32'(mem_addr), 32'd254);
        send_checked("err.len0",     mk(4'h2, 14'd0,   14'd0),     0, 0, 1);
        check("err.len0_keep", 32'(wave_len), 32'd256);
        send_checked("err.len257",   mk(4'h2, 14'd257, 14'd0),     0, 0, 1);
        check("err.len257_keep", 32'(wave_len), 32'd256);
        send_checked("ok.len256",    mk(4'h2, 14'd256, 14'd0),     1, 0, 0);
        check("ok.len256_val", 32'(wave_len), 32'd256);
        send_checked("ok.len100",    mk(4'h2, 14'd100, 14'h3FFF),  1, 0, 0);
        check("ok.len100_val", 32'(wave_len), 32'd100);
        send_checked("ok.addr255",   mk(4'h1, 14'd255, 14'h2AAA),  1, 1, 0);
        check("ok.addr255_ram", 32'(ram[255]), 32'h2AAA);
        send_checked("err.addr256",  mk(4'h1, 14'd256, 14'h1111),  0, 0, 1);
        send_checked("ok.nop",       mk(4'h0, 14'h3FFF, 14'h3FFF), 1, 0, 0);
        frame_end();

        // ---- 5: abort after 17 bits, then a full frame ----------------------
        rx0  = rx_cnt;
        we0  = we_cnt;
        err0 = err_cnt;
        frame_begin();
        spi_bits(mk(4'h1, 14'd9, 14'h0F0F), 31, 15, cap);
        frame_end();
        check("abort.rx_valid",  32'(rx_cnt - rx0),   32'd0);
        check("abort.mem_we",    32'(we_cnt - we0),   32'd0);
        check("abort.frame_err", 32'(err_cnt - err0), 32'd0);
        frame_begin();
        send_checked("abort.next", mk(4'h1, 14'd7, 14'h0ABC), 1, 1, 0);
        frame_end();
        check("abort.next_addr", 32'(mem_addr), 32'd7);
        check("abort.next_ram",  32'(ram[7]),   32'h0ABC);
        check("abort.ram9",      32'(ram[9]),   32'(sine(9)));

        // ---- 6: echo A then B then C, then reset mid-frame ------------------
        fa = mk(4'h0, 14'h1696, 14'h2C3E);
        fb = mk(4'h0, 14'h0123, 14'h0567);
        fc = mk(4'h0, 14'h3A5A, 14'h15A5);
        frame_begin();
        spi_bits(fa, 31, 0, cap);
        check("echo.prev", cap, mk(4'h1, 14'd7, 14'h0ABC));
        spi_bits(fb, 31, 0, cap);
        check("echo.A", cap, fa);
        spi_bits(fc, 31, 0, cap);
        check("echo.B", cap, fb);
        frame_end();

        rx0  = rx_cnt;
        we0  = we_cnt;
        err0 = err_cnt;
        frame_begin();
        spi_bits(mk(4'h1, 14'd20, 14'h1234), 31, 12, cap);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst.wave_len", 32'(wave_len), 32'd256);
        check("mrst.MISO",     32'(MISO),     32'd0);
        spi_bits(mk(4'h1, 14'd20, 14'h1234), 11, 0, cap);
        repeat (5) @(negedge clk);
        check("mrst.rx_valid",  32'(rx_cnt - rx0),   32'd0);
        check("mrst.mem_we",    32'(we_cnt - we0),   32'd0);
        check("mrst.frame_err", 32'(err_cnt - err0), 32'd0);
        frame_end();
        frame_begin();
        send_checked("mrst.after", mk(4'h1, 14'd20, 14'h1234), 1, 1, 0);
        frame_end();
        check("mrst.after_addr", 32'(mem_addr), 32'd20);
        check("mrst.after_data", 32'(mem_wdata), 32'h1234);

        // ---- global invariants ----------------------------------------------
        check("never_both", 32'(both_cnt), 32'd0);
        check("never_oob",  32'(oob_cnt),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
